// File: rtl/cnn_l1_pkg.sv
// Shared definitions for the layer-1 CNN datapath: pixel width, window
// geometry and the tap-index helper used to address packed 3x3 windows.
package cnn_l1_pkg;

    localparam int DATA_W   = 16;
    localparam int WIN_TAPS = 9;

    function automatic int idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/line_buf_l1.sv
// Single-row delay line: register-array circular buffer addressed by the
// current column, returning the old contents before they are overwritten.
module line_buf_l1 #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[addr_i];

    // Contents are deliberately unreset; row/col gating keeps stale data out of windows.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_window_l1.sv
// Layer-1 window generator: turns a row-major pixel stream into packed 3x3
// windows, one per valid convolution position, with a single output stage.
module conv_window_l1 #(
    parameter int DATA_W = cnn_l1_pkg::DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [DATA_W-1:0]                       in_data,
    output logic                                    in_ready,
    output logic                                    win_valid,
    output logic [cnn_l1_pkg::WIN_TAPS*DATA_W-1:0]  win_data,
    input  logic                                    win_ready,
    output logic                                    frame_done
);
    import cnn_l1_pkg::WIN_TAPS;
    import cnn_l1_pkg::idx;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic [WIN_TAPS*DATA_W-1:0] win_q, win_d;
    logic                       win_valid_q, win_valid_d;
    logic                       frame_done_q, frame_done_d;

    logic              accept_s;
    logic              col_last_s;
    logic              row_last_s;
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_rd_s;

    assign in_ready   = win_ready || !win_valid_q;
    assign accept_s   = in_valid && in_ready;
    assign col_last_s = (col_q == CW'(IMG_W - 1));
    assign row_last_s = (row_q == RW'(IMG_H - 1));

    // lb0 delays by one row, lb1 by two rows (fed from lb0's read side).
    line_buf_l1 #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk       (clk),
        .we_i      (accept_s),
        .addr_i    (col_q),
        .wr_data_i (in_data),
        .rd_data_o (lb0_rd_s)
    );

    line_buf_l1 #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk       (clk),
        .we_i      (accept_s),
        .addr_i    (col_q),
        .wr_data_i (lb0_rd_s),
        .rd_data_o (lb1_rd_s)
    );

    // Next-state: position counters, window shift, output-stage valid and frame pulse.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;
        if (accept_s) begin
            if (col_last_s) begin
                col_d = '0;
                row_d = row_last_s ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_d[idx(r, c)*DATA_W +: DATA_W] = win_q[idx(r, c + 1)*DATA_W +: DATA_W];
                end
            end
            win_d[idx(0, 2)*DATA_W +: DATA_W] = lb1_rd_s;
            win_d[idx(1, 2)*DATA_W +: DATA_W] = lb0_rd_s;
            win_d[idx(2, 2)*DATA_W +: DATA_W] = in_data;
            win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_d = col_last_s && row_last_s;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_l1.sv
// Directed bench for conv_window_l1: 4x4 frames (stall, gaps, back-to-back,
// mid-frame reset) on one instance and an 8x3 frame on a second instance.
module tb_conv_window_l1;

    localparam int WW = 144;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          win_ready;
    logic          a_ready, a_valid, a_fd;
    logic [WW-1:0] a_data;
    logic          b_ready, b_valid, b_fd;
    logic [WW-1:0] b_data;

    conv_window_l1 #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_ready), .win_valid(a_valid), .win_data(a_data),
        .win_ready(win_ready), .frame_done(a_fd)
    );

    conv_window_l1 #(.DATA_W(16), .IMG_W(8), .IMG_H(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_ready), .win_valid(b_valid), .win_data(b_data),
        .win_ready(win_ready), .frame_done(b_fd)
    );

    int errors = 0;
    int checks = 0;

    logic          sel;
    logic          mon_on;
    logic [WW-1:0] got[$];
    logic [WW-1:0] exp_q[$];
    int            fd_cnt;
    int            fd_at;

    localparam logic [WW-1:0] FIRST_WIN = 144'h000a_0009_0008_0006_0005_0004_0002_0001_0000;
    localparam logic [WW-1:0] LAST_WIN  = 144'h000f_000e_000d_000b_000a_0009_0007_0006_0005;
    localparam logic [WW-1:0] F2_FIRST  = 144'h006e_006d_006c_006a_0069_0068_0066_0065_0064;

    task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumed windows are those valid while win_ready is high at the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sel ? (b_valid && win_ready) : (a_valid && win_ready))
                got.push_back(sel ? b_data : a_data);
            if (sel ? b_fd : a_fd) begin
                fd_cnt++;
                fd_at = got.size();
            end
        end
    end

    function automatic logic [WW-1:0] exp_win(input int base, input int w, input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[16*(3*i+j) +: 16] = 16'(base + (r - 2 + i) * w + (c - 2 + j));
        return v;
    endfunction

    task automatic build_exp(input int base, input int w, input int h);
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++)
                exp_q.push_back(exp_win(base, w, r, c));
    endtask

    task automatic start_test();
        got.delete();
        exp_q.delete();
        fd_cnt = 0;
        fd_at  = -1;
    endtask

    task automatic drive_pix(input logic [15:0] v);
        int   n;
        logic ok;
        n        = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            @(negedge clk);
            ok = sel ? b_ready : a_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) check_eq("accept_timeout", WW'(0), WW'(1));
    endtask

    task automatic stream(input int base, input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps && ($urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(2, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_pix(16'(base + i));
        end
    endtask

    task automatic finish_stream();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_windows(input string tag);
        check_eq({tag, "_count"}, WW'(got.size()), WW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq($sformatf("%s_win%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        win_ready = 1'b1;
        sel       = 1'b0;
        mon_on    = 1'b0;
        fd_cnt    = 0;
        fd_at     = -1;

        #12;
        check_eq("rst_win_valid", WW'(a_valid), WW'(0));
        check_eq("rst_in_ready", WW'(a_ready), WW'(1));
        check_eq("rst_frame_done", WW'(a_fd), WW'(0));
        check_eq("rst_win_data", a_data, WW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // Continuous flow, consumer always ready.
        start_test();
        build_exp(0, 4, 4);
        stream(0, 16, 1'b0);
        finish_stream();
        compare_windows("nostall");
        if (got.size() >= 4) begin
            check_eq("nostall_first", got[0], FIRST_WIN);
            check_eq("nostall_last", got[3], LAST_WIN);
        end else begin
            check_eq("nostall_have4", WW'(got.size()), WW'(4));
        end
        check_eq("nostall_fd_cnt", WW'(fd_cnt), WW'(1));
        check_eq("nostall_fd_at", WW'(fd_at), WW'(4));

        // Consumer stalls for 3 cycles right after the first window appears.
        start_test();
        build_exp(0, 4, 4);
        for (int i = 0; i < 16; i++) begin
            drive_pix(16'(i));
            if (i == 10) begin
                win_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 16'd11;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", WW'(a_ready), WW'(0));
                    check_eq("stall_win_valid", WW'(a_valid), WW'(1));
                    check_eq("stall_win_data", a_data, FIRST_WIN);
                    @(posedge clk);
                    #1;
                end
                win_ready = 1'b1;
            end
        end
        finish_stream();
        compare_windows("stall");

        // Random input gaps.
        start_test();
        build_exp(0, 4, 4);
        stream(0, 16, 1'b1);
        finish_stream();
        compare_windows("gaps");
        check_eq("gaps_fd_cnt", WW'(fd_cnt), WW'(1));

        // Two back-to-back frames.
        start_test();
        build_exp(0, 4, 4);
        build_exp(100, 4, 4);
        stream(0, 16, 1'b0);
        stream(100, 16, 1'b0);
        finish_stream();
        compare_windows("b2b");
        if (got.size() >= 5) check_eq("b2b_f2_first", got[4], F2_FIRST);
        else check_eq("b2b_have5", WW'(got.size()), WW'(5));
        check_eq("b2b_fd_cnt", WW'(fd_cnt), WW'(2));

        // Asynchronous reset after pixel 9, then a fresh frame.
        start_test();
        stream(0, 10, 1'b0);
        in_valid = 1'b0;
        check_eq("prerst_no_win", WW'(got.size()), WW'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_win_valid", WW'(a_valid), WW'(0));
        check_eq("arst_win_data", a_data, WW'(0));
        check_eq("arst_frame_done", WW'(a_fd), WW'(0));
        check_eq("arst_in_ready", WW'(a_ready), WW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_test();
        build_exp(0, 4, 4);
        stream(0, 16, 1'b0);
        finish_stream();
        compare_windows("postrst");
        check_eq("postrst_fd_at", WW'(fd_at), WW'(4));

        // Wide, shallow image on the second instance.
        sel = 1'b1;
        do_reset();
        start_test();
        build_exp(0, 8, 3);
        stream(0, 24, 1'b0);
        finish_stream();
        compare_windows("w8h3");
        check_eq("w8h3_fd_cnt", WW'(fd_cnt), WW'(1));
        check_eq("w8h3_fd_at", WW'(fd_at), WW'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
